// File: rtl/receptor_array.sv
// receptor_array: per-lane receptor FSMs (IDLE/HELD/FADE) with press edge
// pulses, a frame-timed release fade and a combinational pixel decoder for
// the receptor strip of the note highway.
// Optional feature: define RECEPTOR_ARRAY_MULTIKEY_EN to add the keycode2
// port so that two keys can hold two lanes at once.

module receptor_lane #(
  parameter int FADE_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       i_hit,
  input  logic       i_tick,
  output logic       o_press,
  output logic       o_held,
  output logic       o_active,
  output logic [3:0] o_glow
);
  typedef enum logic [1:0] {S_IDLE, S_HELD, S_FADE} state_t;

  localparam logic [3:0] FADE_INIT = (FADE_FRAMES == 0) ? 4'd0 : 4'(FADE_FRAMES - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_press, w_press_nxt;

  // state, fade counter and registered press pulse
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_press <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_press <= w_press_nxt;
    end
  end

  // next-state: a hit always beats a frame tick in FADE
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press_nxt = 1'b0;
    case (r_state)
      S_IDLE: if (i_hit) begin
        w_state_nxt = S_HELD;
        w_press_nxt = 1'b1;
      end
      S_HELD: if (!i_hit) begin
        if (FADE_FRAMES == 0) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_state_nxt = S_FADE;
          w_cnt_nxt   = FADE_INIT;
        end
      end
      S_FADE: begin
        if (i_hit) begin
          w_state_nxt = S_HELD;
          w_press_nxt = 1'b1;
        end else if (i_tick) begin
          if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
          else               w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // glow: full while held, counts down through the fade
  always_comb begin
    o_glow = 4'd0;
    case (r_state)
      S_HELD:  o_glow = 4'hF;
      S_FADE:  o_glow = r_cnt + 4'd1;
      default: o_glow = 4'd0;
    endcase
  end

  assign o_press  = r_press;
  assign o_held   = (r_state == S_HELD);
  assign o_active = (r_state != S_IDLE);
endmodule

module receptor_array #(
  parameter int NUM_LANES   = 4,
  parameter int LANE_W      = 32,
  parameter int X0          = 256,
  parameter int Y0          = 400,
  parameter int RECEPTOR_H  = 50,
  parameter int FADE_FRAMES = 8,
  parameter logic [8*NUM_LANES-1:0] KEYMAP = {8'h3b, 8'h35, 8'h33, 8'h34}
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_clk,
  input  logic [7:0]           keycode,
`ifdef RECEPTOR_ARRAY_MULTIKEY_EN
  input  logic [7:0]           keycode2,
`endif
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  output logic [NUM_LANES-1:0] press_pulse,
  output logic [NUM_LANES-1:0] lane_held,
  output logic [NUM_LANES-1:0] is_receptor,
  output logic                 is_background,
  output logic                 is_receptor_background,
  output logic [3:0]           pixel_glow
);
  logic                            r_fclk_d, r_tick;
  logic [NUM_LANES-1:0]            w_hit, w_active, w_in_lane;
  logic [NUM_LANES-1:0][3:0]       w_glow;
  logic [31:0]                     w_x, w_y, w_dx;
  logic                            w_in_bg, w_in_strip;

  // frame_clk rising edge -> one-cycle tick; history resets high so a
  // frame_clk already high at reset release is not taken as an edge
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fclk_d <= 1'b1;
      r_tick   <= 1'b0;
    end else begin
      r_fclk_d <= frame_clk;
      r_tick   <= frame_clk & ~r_fclk_d;
    end
  end

  assign w_x        = 32'(DrawX);
  assign w_y        = 32'(DrawY);
  assign w_dx       = w_x - 32'(X0);
  assign w_in_bg    = (w_x >= 32'(X0)) && (w_x < 32'(X0 + NUM_LANES*LANE_W));
  assign w_in_strip = (w_y >= 32'(Y0)) && (w_y < 32'(Y0 + RECEPTOR_H));

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [7:0] w_key;
    assign w_key = KEYMAP[8*i +: 8];
`ifdef RECEPTOR_ARRAY_MULTIKEY_EN
    assign w_hit[i] = ((keycode != 8'h00) && (keycode == w_key)) ||
                      ((keycode2 != 8'h00) && (keycode2 == w_key));
`else
    assign w_hit[i] = (keycode != 8'h00) && (keycode == w_key);
`endif
    // lane window by range compare; no divide of (DrawX-X0)
    assign w_in_lane[i] = w_in_bg && (w_dx >= 32'(i*LANE_W)) && (w_dx < 32'((i+1)*LANE_W));
    assign is_receptor[i] = w_in_lane[i] && w_in_strip && w_active[i];

    receptor_lane #(.FADE_FRAMES(FADE_FRAMES)) u_lane (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .i_hit    (w_hit[i]),
      .i_tick   (r_tick),
      .o_press  (press_pulse[i]),
      .o_held   (lane_held[i]),
      .o_active (w_active[i]),
      .o_glow   (w_glow[i])
    );
  end

  // lanes are disjoint, so OR-ing the masked glows selects the one under the pixel
  always_comb begin
    pixel_glow = 4'd0;
    for (int i = 0; i < NUM_LANES; i++)
      if (w_in_lane[i] && w_in_strip) pixel_glow = pixel_glow | w_glow[i];
  end

  assign is_background          = w_in_bg;
  assign is_receptor_background = w_in_bg && w_in_strip;
endmodule

// File: tb/tb_receptor_array.sv
// Directed bench for receptor_array: reset, press pulse, fade sequence,
// re-press on a tick, zero-length fade, pixel edges, optional two-key hold.
module tb_receptor_array;
  logic       Clk = 1'b0;
  logic       Reset_n, frame_clk;
  logic [7:0] keycode, keycode2;
  logic [9:0] DrawX, DrawY;
  logic [3:0] press_pulse, lane_held, is_receptor, pixel_glow;
  logic       is_background, is_receptor_background;
  logic [3:0] z_press, z_held, z_rec, z_glow;
  logic       z_bg, z_rbg;

  int n_cmp = 0;
  int n_err = 0;
  int pulses;

  always #5 Clk = ~Clk;

  receptor_array u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
`ifdef RECEPTOR_ARRAY_MULTIKEY_EN
    .keycode2(keycode2),
`endif
    .DrawX(DrawX), .DrawY(DrawY), .press_pulse(press_pulse), .lane_held(lane_held),
    .is_receptor(is_receptor), .is_background(is_background),
    .is_receptor_background(is_receptor_background), .pixel_glow(pixel_glow)
  );

  receptor_array #(.FADE_FRAMES(0)) u_dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
`ifdef RECEPTOR_ARRAY_MULTIKEY_EN
    .keycode2(keycode2),
`endif
    .DrawX(DrawX), .DrawY(DrawY), .press_pulse(z_press), .lane_held(z_held),
    .is_receptor(z_rec), .is_background(z_bg),
    .is_receptor_background(z_rbg), .pixel_glow(z_glow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one frame_clk high/low period; the tick is consumed before it returns
  task automatic frame_pulse();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk) Reset_n = 1'b0;
    keycode = 8'h00; keycode2 = 8'h00; frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  typedef struct { int x; int y; logic bg; logic rbg; } pix_t;
  pix_t pix[8];

  initial begin
    Reset_n = 1'b0; frame_clk = 1'b0; keycode = 8'h00; keycode2 = 8'h00;
    DrawX = 10'd260; DrawY = 10'd420;
    repeat (2) @(negedge Clk);
    chk("rst_press", press_pulse, 4'b0000);
    chk("rst_held",  lane_held,   4'b0000);
    chk("rst_rec",   is_receptor, 4'b0000);
    chk("rst_glow",  pixel_glow,  4'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // press lane 0, hold 10 cycles, single pulse
    keycode = 8'h34;
    pulses = 0;
    @(negedge Clk);
    chk("a_press", press_pulse, 4'b0001);
    chk("a_held",  lane_held,   4'b0001);
    chk("a_glow",  pixel_glow,  4'd15);
    chk("a_rec",   is_receptor, 4'b0001);
    for (int c = 0; c < 9; c++) begin
      @(negedge Clk);
      if (press_pulse[0]) pulses++;
    end
    chk("a_one_pulse", pulses, 0);
    keycode = 8'h00;
    @(negedge Clk);
    chk("a_rel_held", lane_held,  4'b0000);
    chk("a_rel_glow", pixel_glow, 4'd8);
    for (int k = 1; k <= 8; k++) begin
      frame_pulse();
      chk($sformatf("a_fade%0d", k), pixel_glow, (k < 8) ? 8 - k : 0);
    end
    chk("a_idle_rec", is_receptor, 4'b0000);

    // fade down to cnt 3, re-press in the same cycle as the tick
    @(negedge Clk) keycode = 8'h34;
    @(negedge Clk) keycode = 8'h00;
    for (int k = 0; k < 4; k++) frame_pulse();
    chk("b_glow4", pixel_glow, 4'd4);
    frame_clk = 1'b1;
    @(negedge Clk) keycode = 8'h34;
    @(negedge Clk);
    chk("b_held",  lane_held,   4'b0001);
    chk("b_press", press_pulse, 4'b0001);
    chk("b_glow",  pixel_glow,  4'd15);
    frame_clk = 1'b0;
    do_reset();

    // zero-length fade on the FADE_FRAMES=0 instance, lane 3
    DrawX = 10'd370;
    @(negedge Clk) keycode = 8'h3b;
    @(negedge Clk);
    chk("c_held", z_held, 4'b1000);
    chk("c_rec",  z_rec,  4'b1000);
    keycode = 8'h00;
    @(negedge Clk);
    chk("c_idle", z_held, 4'b0000);
    chk("c_rec0", z_rec,  4'b0000);
    chk("c_glow", z_glow, 4'd0);
    do_reset();

    // reset while lane 2 is held
    DrawX = 10'd330;
    @(negedge Clk) keycode = 8'h35;
    @(negedge Clk);
    chk("d_held", lane_held, 4'b0100);
    #2 Reset_n = 1'b0;
    #1;
    chk("d_rst_held",  lane_held,   4'b0000);
    chk("d_rst_glow",  pixel_glow,  4'd0);
    chk("d_rst_rec",   is_receptor, 4'b0000);
    chk("d_rst_press", press_pulse, 4'b0000);
    @(negedge Clk) Reset_n = 1'b1;
    @(negedge Clk);
    chk("d_press", press_pulse, 4'b0100);
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      if (press_pulse[2]) pulses++;
    end
    chk("d_one_pulse", pulses, 0);

    // pixel edges with lane 2 still held
    pix[0] = '{255, 420, 1'b0, 1'b0}; pix[1] = '{256, 420, 1'b1, 1'b1};
    pix[2] = '{383, 420, 1'b1, 1'b1}; pix[3] = '{384, 420, 1'b0, 1'b0};
    pix[4] = '{300, 399, 1'b1, 1'b0}; pix[5] = '{300, 400, 1'b1, 1'b1};
    pix[6] = '{300, 449, 1'b1, 1'b1}; pix[7] = '{300, 450, 1'b1, 1'b0};
    for (int p = 0; p < 8; p++) begin
      DrawX = 10'(pix[p].x); DrawY = 10'(pix[p].y);
      #1;
      chk($sformatf("e_bg_%0d_%0d",  pix[p].x, pix[p].y), is_background,          pix[p].bg);
      chk($sformatf("e_rbg_%0d_%0d", pix[p].x, pix[p].y), is_receptor_background, pix[p].rbg);
    end
    DrawY = 10'd420;
    DrawX = 10'd319; #1 chk("e_rec319", is_receptor, 4'b0000);
    DrawX = 10'd320; #1 chk("e_rec320", is_receptor, 4'b0100);
    DrawX = 10'd351; #1 chk("e_rec351", is_receptor, 4'b0100);
    DrawX = 10'd352; #1 chk("e_rec352", is_receptor, 4'b0000);
    chk("e_glow352", pixel_glow, 4'd0);
    DrawX = 10'd340; DrawY = 10'd450; #1 chk("e_glow_out", pixel_glow, 4'd0);

`ifdef RECEPTOR_ARRAY_MULTIKEY_EN
    do_reset();
    @(negedge Clk) begin keycode = 8'h34; keycode2 = 8'h3b; end
    @(negedge Clk);
    chk("f_held",  lane_held,   4'b1001);
    chk("f_press", press_pulse, 4'b1001);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
